// File: rtl/ahb_lite_subordinate_mem.sv
// Memory-backed AHB-lite subordinate: pipelined address/data phases, per-lane writes,
// optional wait states on OKAY transfers and the two-cycle ERROR response.
module ahb_lite_subordinate_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  active_q, active_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [LSB-1:0]        off_q, off_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  capture;
    logic                  legal;
    logic                  complete;
    logic [ADDR_WIDTH-1:0] align_mask;
    logic [NBYTES-1:0]     be;
    logic                  unused_inputs;

    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

    assign capture    = HSEL && HREADY && HTRANS[1];
    assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
    assign legal      = (HSIZE <= 3'(LSB))
                     && ((HADDR & align_mask) == '0)
                     && ((HADDR >> LSB) < ADDR_WIDTH'(MEM_DEPTH));

    // A legal data phase completes in the first IDLE cycle after capture/waits.
    assign complete = active_q && (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        write_d  = write_q;
        size_d   = size_q;
        off_d    = off_q;
        idx_d    = idx_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR1: begin
                state_d = S_ERR2;
            end
            default: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
                if (capture) begin
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    off_d   = HADDR[LSB-1:0];
                    idx_d   = HADDR[LSB +: IDX_W];
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else begin
                        active_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d = S_WAIT;
                            cnt_d   = 4'(WAIT_STATES);
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= '0;
            off_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            write_q  <= write_d;
            size_q   <= size_d;
            off_q    <= off_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        be = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if ((b >= int'(off_q)) && (b < int'(off_q) + (1 << size_q))) begin
                be[b] = 1'b1;
            end
        end
    end

    // Memory has no reset so contents survive HRESET.
    always_ff @(posedge clk) begin
        if (!HRESET && complete && write_q) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
    end

    assign HREADYOUT = HRESET || !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = !HRESET && ((state_q == S_ERR1) || (state_q == S_ERR2));
    assign HRDATA    = (!HRESET && complete && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_subordinate_mem.sv
// Bench for ahb_lite_subordinate_mem: three instances (0, 2 and 3 wait states) checked
// every cycle against a transaction-level memory/response model.
module tb_ahb_lite_subordinate_mem;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  hreset;
    logic [2:0]  hsel;
    logic [2:0]  hwrite;
    logic [31:0] haddr  [3];
    logic [1:0]  htrans [3];
    logic [2:0]  hsize  [3];
    logic [31:0] hwdata [3];
    wire  [2:0]  hready;
    wire  [2:0]  hresp;
    wire  [31:0] hrdata [3];

    logic [2:0]  rdy_s;
    logic [31:0] mem_m [3][256];
    exp_t        expq  [3][$];
    bit          cmp_en = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_lite_subordinate_mem #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_DEPTH  (256),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk      (clk),
            .HRESET   (hreset[g]),
            .HSEL     (hsel[g]),
            .HADDR    (haddr[g]),
            .HWRITE   (hwrite[g]),
            .HTRANS   (htrans[g]),
            .HSIZE    (hsize[g]),
            .HBURST   (3'b001),
            .HPROT    (4'b0011),
            .HWDATA   (hwdata[g]),
            .HREADY   (hready[g]),
            .HREADYOUT(hready[g]),
            .HRESP    (hresp[g]),
            .HRDATA   (hrdata[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) rdy_s = hready;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 3; d++) begin
                exp_t e;
                if (expq[d].size() > 0) e = expq[d].pop_front();
                else                    e = '{1'b1, 1'b0, 32'd0};
                chk($sformatf("cyc_rdy_d%0d", d),  32'(hready[d]), 32'(e.rdy));
                chk($sformatf("cyc_resp_d%0d", d), 32'(hresp[d]),  32'(e.resp));
                chk($sformatf("cyc_data_d%0d", d), hrdata[d],      e.data);
            end
        end
    end

    // Drive one address phase, wait for its acceptance, then present its write data and
    // record the responses the data phase must produce.
    task automatic xfer(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input bit commit);
        bit ok = 0;
        hsel[d]   = sel;
        htrans[d] = trans;
        hwrite[d] = wr;
        haddr[d]  = addr;
        hsize[d]  = size;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (rdy_s[d]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        #1;
        hwdata[d] = wdata;
        if (sel && trans[1]) begin
            bit legal;
            legal = (size <= 3'd2) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0)
                 && ((addr >> 2) < 32'd256);
            if (legal) begin
                int idx = int'(addr >> 2);
                for (int i = 0; i < ws_of(d); i++) expq[d].push_back('{1'b0, 1'b0, 32'd0});
                expq[d].push_back('{1'b1, 1'b0, wr ? 32'd0 : mem_m[d][idx]});
                if (wr && commit) begin
                    for (int k = 0; k < (1 << size); k++) begin
                        int lane = int'(addr[1:0]) + k;
                        mem_m[d][idx][8*lane +: 8] = wdata[8*lane +: 8];
                    end
                end
            end else begin
                expq[d].push_back('{1'b0, 1'b1, 32'd0});
                expq[d].push_back('{1'b1, 1'b1, 32'd0});
            end
        end
    endtask

    task automatic idle(input int d);
        xfer(d, 1'b0, T_IDLE, 1'b0, 32'd0, 3'd0, 32'd0, 1'b1);
    endtask

    task automatic expect_done(input int d, input logic [31:0] exp, input int exp_lows,
                               input string nm);
        int lows = 0;
        bit ok   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (hready[d]) begin
                ok = 1;
                break;
            end
            lows++;
        end
        if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
        chk({nm, "_data"}, hrdata[d], exp);
        chk({nm, "_waits"}, 32'(lows), 32'(exp_lows));
    endtask

    task automatic expect_resp(input int d, input logic rdy, input logic resp, input string nm);
        @(negedge clk);
        chk({nm, "_rdy"},  32'(hready[d]), 32'(rdy));
        chk({nm, "_resp"}, 32'(hresp[d]),  32'(resp));
        chk({nm, "_data"}, hrdata[d],      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        hreset = 3'b111;
        hsel   = '0;
        hwrite = '0;
        for (int d = 0; d < 3; d++) begin
            haddr[d] = '0; htrans[d] = T_IDLE; hsize[d] = '0; hwdata[d] = '0;
            for (int w = 0; w < 256; w++) mem_m[d][w] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        hreset = 3'b000;
        cmp_en = 1;
        for (int d = 0; d < 3; d++) expect_resp(d, 1'b1, 1'b0, $sformatf("reset_d%0d", d));

        // Zero-wait pipeline: write then read the same word back-to-back
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'hDEADBEEF, 0, "pipe_rd");

        // Byte lanes
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h20, 3'd2, 32'h11223344, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h21, 3'd0, 32'h0000AA00, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 0, 32'h20, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'h1122AA44, 0, "lane_rd");
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h22, 3'd1, 32'h77660000, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 0, 32'h20, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'h7766AA44, 0, "half_rd");

        // Errors: misaligned word write, out-of-range read, oversize transfer
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h22, 3'd2, 32'h55555555, 1'b1);
        expect_resp(0, 1'b0, 1'b1, "misal_err1");
        expect_resp(0, 1'b1, 1'b1, "misal_err2");
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h20, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'h7766AA44, 0, "misal_rd");
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h400, 3'd2, 32'h0, 1'b1);
        expect_resp(0, 1'b0, 1'b1, "oor_err1");
        expect_resp(0, 1'b1, 1'b1, "oor_err2");
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h3FC, 3'd2, 32'h0, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h40, 3'd3, 32'h0, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'hDEADBEEF, 0, "after_size_err");

        // BUSY inside a burst and an unselected transfer
        xfer(0, 1'b1, T_NONSEQ, 1'b1, 32'h30, 3'd2, 32'h01010101, 1'b1);
        xfer(0, 1'b1, T_BUSY,   1'b1, 32'h34, 3'd2, 32'hBAD0BAD0, 1'b1);
        xfer(0, 1'b1, T_SEQ,    1'b1, 32'h34, 3'd2, 32'h02020202, 1'b1);
        xfer(0, 1'b0, T_NONSEQ, 1'b1, 32'h30, 3'd2, 32'hFFFFFFFF, 1'b1);
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h30, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'h01010101, 0, "busy_rd30");
        xfer(0, 1'b1, T_NONSEQ, 1'b0, 32'h34, 3'd2, 32'h0, 1'b1);
        expect_done(0, 32'h02020202, 0, "busy_rd34");
        idle(0);

        // Two wait states, including a next address held through the waits
        xfer(1, 1'b1, T_NONSEQ, 1'b1, 32'h08, 3'd2, 32'hA5A5A5A5, 1'b1);
        xfer(1, 1'b1, T_NONSEQ, 1'b1, 32'h0C, 3'd2, 32'h5A5A0F0F, 1'b1);
        xfer(1, 1'b1, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h0, 1'b1);
        expect_done(1, 32'hA5A5A5A5, 2, "ws2_rd08");
        xfer(1, 1'b1, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h0, 1'b1);
        xfer(1, 1'b1, T_NONSEQ, 1'b0, 32'h0C, 3'd2, 32'h0, 1'b1);
        expect_done(1, 32'h5A5A0F0F, 2, "ws2_held_rd0c");
        xfer(1, 1'b1, T_NONSEQ, 1'b0, 32'h07, 3'd2, 32'h0, 1'b1);
        expect_resp(1, 1'b0, 1'b1, "ws2_err1");
        expect_resp(1, 1'b1, 1'b1, "ws2_err2");
        idle(1);

        // Reset in the middle of a three-wait-state write
        xfer(2, 1'b1, T_NONSEQ, 1'b1, 32'h40, 3'd2, 32'h12345678, 1'b1);
        xfer(2, 1'b1, T_NONSEQ, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 1'b0);
        @(posedge clk);
        #1;
        hreset[2] = 1'b1;
        hsel[2]   = 1'b0;
        htrans[2] = T_IDLE;
        expq[2].delete();
        expect_resp(2, 1'b1, 1'b0, "rst_cyc1");
        expect_resp(2, 1'b1, 1'b0, "rst_cyc2");
        @(posedge clk);
        #1;
        hreset[2] = 1'b0;
        xfer(2, 1'b1, T_NONSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 1'b1);
        expect_done(2, 32'h12345678, 3, "rst_rd40");
        idle(2);

        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("drain_d%0d", d), 32'(expq[d].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
